// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap entry / mret sequencer.
//   On a trap it saves mepc/mcause, optionally updates mstatus, then fetches
//   mtvec and issues a one-cycle fetch redirect. On mret it reads mepc,
//   optionally restores mstatus, then issues the redirect.
// Build option: define TRAP_MSTATUS_EN to enable mstatus save/restore
//   (adds the STAT/RSTAT states, one extra cycle of latency each way).
// Ports:
//   i_clk, i_rst_n              clock, synchronous active-low reset
//   i_trap_valid/_pc/_cause     trap request, faulting PC, mcause value
//   i_mret_valid                mret request
//   o_trap_ready, o_busy        request accepted this cycle (IDLE) / not IDLE
//   o_csr_raddr, i_csr_rdata    CSR read port (combinational data)
//   o_csr_waddr1/wdata1/wena1   CSR write port 1
//   o_csr_waddr2/wdata2/wena2   CSR write port 2
//   o_redirect_valid/_pc        fetch redirect
module trap_ctrl (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_trap_valid,
  input  logic [31:0] i_trap_pc,
  input  logic [31:0] i_trap_cause,
  input  logic        i_mret_valid,
  output logic        o_trap_ready,
  output logic [11:0] o_csr_raddr,
  input  logic [31:0] i_csr_rdata,
  output logic [11:0] o_csr_waddr1,
  output logic [31:0] o_csr_wdata1,
  output logic        o_csr_wena1,
  output logic [11:0] o_csr_waddr2,
  output logic [31:0] o_csr_wdata2,
  output logic        o_csr_wena2,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  output logic        o_busy
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    S_IDLE, S_SAVE, S_STAT, S_VECTOR, S_RET, S_RSTAT, S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pc;
  logic [31:0] r_cause;
  logic [31:0] r_redirect_pc;
  logic        w_trap_acc;
  logic        w_redirect_ld;
  logic [31:0] w_target;
  logic        w_unused;

  // Redirect targets are word aligned: the low two bits of mtvec are the
  // mode field and are dropped.
  assign w_target = {i_csr_rdata[31:2], 2'b00};
  assign w_unused = ^i_csr_rdata[1:0];

`ifdef TRAP_MSTATUS_EN
  logic [31:0] w_ms_trap;
  logic [31:0] w_ms_ret;

  // Trap: MPIE <= MIE, MIE <= 0, MPP <= M. Return: MIE <= MPIE, MPIE <= 1, MPP <= U.
  always_comb begin
    w_ms_trap        = i_csr_rdata;
    w_ms_trap[7]     = i_csr_rdata[3];
    w_ms_trap[3]     = 1'b0;
    w_ms_trap[12:11] = 2'b11;
    w_ms_ret         = i_csr_rdata;
    w_ms_ret[3]      = i_csr_rdata[7];
    w_ms_ret[7]      = 1'b1;
    w_ms_ret[12:11]  = 2'b00;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= '0;
      r_cause       <= '0;
      r_redirect_pc <= '0;
    end else begin
      r_state <= w_next;
      if (w_trap_acc) begin
        r_pc    <= i_trap_pc;
        r_cause <= i_trap_cause;
      end
      if (w_redirect_ld) r_redirect_pc <= w_target;
    end
  end

  always_comb begin
    w_next           = r_state;
    w_trap_acc       = 1'b0;
    w_redirect_ld    = 1'b0;
    o_trap_ready     = 1'b0;
    o_csr_raddr      = '0;
    o_csr_waddr1     = '0;
    o_csr_wdata1     = '0;
    o_csr_wena1      = 1'b0;
    o_csr_waddr2     = '0;
    o_csr_wdata2     = '0;
    o_csr_wena2      = 1'b0;
    o_redirect_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_trap_ready = 1'b1;
        if (i_trap_valid) begin
          w_trap_acc = 1'b1;
          w_next     = S_SAVE;
        end else if (i_mret_valid) begin
          w_next = S_RET;
        end
      end
      S_SAVE: begin
        o_csr_wena1  = 1'b1;
        o_csr_waddr1 = CSR_MEPC;
        o_csr_wdata1 = r_pc;
        o_csr_wena2  = 1'b1;
        o_csr_waddr2 = CSR_MCAUSE;
        o_csr_wdata2 = r_cause;
`ifdef TRAP_MSTATUS_EN
        w_next = S_STAT;
`else
        w_next = S_VECTOR;
`endif
      end
      S_STAT: begin
`ifdef TRAP_MSTATUS_EN
        o_csr_raddr  = CSR_MSTATUS;
        o_csr_wena1  = 1'b1;
        o_csr_waddr1 = CSR_MSTATUS;
        o_csr_wdata1 = w_ms_trap;
        w_next       = S_VECTOR;
`else
        w_next = S_IDLE;
`endif
      end
      S_VECTOR: begin
        o_csr_raddr   = CSR_MTVEC;
        w_redirect_ld = 1'b1;
        w_next        = S_DONE;
      end
      S_RET: begin
        o_csr_raddr   = CSR_MEPC;
        w_redirect_ld = 1'b1;
`ifdef TRAP_MSTATUS_EN
        w_next = S_RSTAT;
`else
        w_next = S_DONE;
`endif
      end
      S_RSTAT: begin
`ifdef TRAP_MSTATUS_EN
        o_csr_raddr  = CSR_MSTATUS;
        o_csr_wena1  = 1'b1;
        o_csr_waddr1 = CSR_MSTATUS;
        o_csr_wdata1 = w_ms_ret;
        w_next       = S_DONE;
`else
        w_next = S_IDLE;
`endif
      end
      S_DONE: begin
        o_redirect_valid = 1'b1;
        w_next           = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign o_busy        = ~o_trap_ready;
  assign o_redirect_pc = r_redirect_pc;

endmodule
